button_encoder: RTL
===================

# button_encoder

Input-side companion to `segment_decoder` on the iCEBreaker break-off board. It synchronizes and debounces the board push-buttons, detects press events, and priority-encodes each event into a button index with a one-cycle valid strobe. It also keeps a toggling `selector` bit that drives `segment_decoder` directly. Consumers are the LED pattern logic and future game-state blocks.

## Interface
Parameters:
- `N_BTN`, 3: number of buttons; legal range 2..8.
- `DEBOUNCE_CYCLES`, 120000: cycles a changed level must stay stable before it is accepted (10 ms at 12 MHz); minimum 2.
- `ACTIVE_LOW`, 0: when 1, raw inputs are inverted before synchronization.

Ports:
- `CLK`, input, 1: single clock for the whole block.
- `RST`, input, 1: synchronous reset, active-high.
- `BTN`, input, N_BTN: raw asynchronous button levels.
- `held`, output, N_BTN: debounced button levels (1 = pressed).
- `code`, output, CODE_W = clog2(N_BTN): index of the most recently pressed button; holds its value between events.
- `press_valid`, output, 1: one-cycle strobe; `code` is new in the same cycle.
- `selector`, output, 1: toggles on each accepted press of button 0.

## Operation
- Synchronizer: each `BTN` bit goes through a 2-flop synchronizer; the `ACTIVE_LOW` inversion is applied before the first flop.
- Debounce, per button (`btn_debounce`):
  - Holds the debounced state `db` and a counter `cnt` of width clog2(DEBOUNCE_CYCLES).
  - Synchronized level equal to `db`: `cnt` <= 0.
  - Level differs and `cnt` = DEBOUNCE_CYCLES-1: `db` flips and `cnt` <= 0.
  - Level differs otherwise: `cnt` increments.
  - Consequence: any bounce shorter than DEBOUNCE_CYCLES restarts the count and is never accepted.
- Edge detect: `rise[i] = db[i] & ~db_q[i]`, where `db_q` is `db` delayed one cycle. Releases produce no event.
- Priority encode: if any `rise` bit is set, `code` <= lowest set index and `press_valid` <= 1. Otherwise `press_valid` <= 0 and `code` holds.
- Simultaneous rises: only the lowest index is reported. Higher-index rises in the same cycle are dropped, not queued.
- Selector: toggles in the same cycle that `press_valid` asserts with `code` = 0.
- Reset values: all synchronizer flops, `db`, `db_q`, `cnt` = 0; `held` = 0, `code` = 0, `press_valid` = 0, `selector` = 0.
  - A button already held through reset is treated as a new press once it has been stable for DEBOUNCE_CYCLES cycles after reset releases.
- Reset mid-count: `RST` aborts the count. No strobe is produced in the cycle `RST` is high.

## Timing
- Cycle numbering: the first rising edge of `CLK` that samples the new stable `BTN` level is edge 0.
  - Synchronizer output changes at edge 1.
  - `db` flips at edge 1 + DEBOUNCE_CYCLES.
  - `held` is driven from `db`, so `held` changes at the same edge.
  - `press_valid` and `code` update at edge 2 + DEBOUNCE_CYCLES.
  - Total press latency: DEBOUNCE_CYCLES + 2 cycles after edge 0.
- Release latency to `held` falling: DEBOUNCE_CYCLES + 1 cycles.
- `press_valid` is high for exactly 1 cycle per accepted press.
- Minimum spacing between strobes from the same button is 2·DEBOUNCE_CYCLES cycles, because the release must also be debounced.
- All outputs are registered. There is no combinational path from `BTN` to any output.

## Structure
- Package `btn_pkg` holds:
  - `DEBOUNCE_10MS_12MHZ` = 120000.
  - A `clog2`-based width function for `code`/`cnt`.
  - An `N_BTN_MAX` = 8 constant.
- Sub-module `btn_debounce`: one button, containing the synchronizer, counter and `db` register. It is instantiated N_BTN times with a generate loop.
- `button_encoder` top contains the edge detect, priority encoder and selector toggle.
- The iCEBreaker top connects `BTN1..BTN3` to `BTN` and `selector` to `segment_decoder`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `N_BTN`=3, `ACTIVE_LOW`=0.
- Reset: `RST` high for 3 cycles with `BTN`=3'b000 -> all outputs 0 throughout and for 10 cycles after release.
- Clean press: `BTN[1]` rises and stays high -> `held[1]`=1 at edge 5, single `press_valid` at edge 6 with `code`=1, `selector` stays 0.
- Bounce rejection: `BTN[2]` toggles high/low every 2 cycles for 20 cycles, then goes low -> `held`=0, no `press_valid`. A subsequent stable high for 6 cycles -> one strobe with `code`=2.
- Simultaneous press: `BTN`=3'b111 in one cycle, held -> exactly one strobe with `code`=0, `selector` flips 0->1, `held`=3'b111.
- Selector toggle: three separate debounced press/release cycles on `BTN[0]` -> three strobes with `code`=0, `selector` sequence 1,0,1. The release phases produce no strobes.
- Reset mid-count: `BTN[0]` high, `RST` pulsed at cycle 3 of the debounce count -> no strobe before reset. After release, a strobe occurs at 6 cycles past `RST` deassertion, since the button is still held.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and width helper for the push-button input path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

    // 10 ms of stable level at the 12 MHz board clock.
    localparam int DEBOUNCE_10MS_12MHZ = 120000;

    // Largest button count the encoder is sized for.
    localparam int N_BTN_MAX = 8;

    // Bits needed to hold values 0..n-1; never narrower than one bit so
    // that degenerate parameter values still yield a legal vector.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: optional inversion, 2-flop synchronizer, stable-level debounce counter.
// Latency: db follows a stable raw level DEBOUNCE_CYCLES+1 cycles after it is first sampled.
// Backpressure: none; free-running, output is a level.
//
// Ports: clk/rst (sync active-high), raw (asynchronous pad level),
//        db (debounced level, 1 = pressed).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = idx_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Polarity is fixed before the first flop so the synchronizer and
    // counter always see 1 = pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

    // Any return to the accepted level clears the count, so a bounce
    // shorter than DEBOUNCE_CYCLES never gets through.
    always_ff @(posedge clk) begin
        if (rst) begin
            db  <= 1'b0;
            cnt <= '0;
        end else if (sync2 == db) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            db  <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_encoder.sv
// Debounced button press detector with priority-encoded index strobe and button-0 toggle.
// Latency: press_valid/code DEBOUNCE_CYCLES+2 cycles after a new stable level is first sampled.
// Backpressure: none; one-cycle strobe, simultaneous higher-index presses are dropped.
//
// Ports: CLK, RST (sync active-high), BTN (raw levels),
//        held (debounced levels), code (last pressed index, holds),
//        press_valid (1-cycle strobe with new code), selector (toggles on button 0 press).
module button_encoder
    import btn_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_12MHZ,
    parameter bit ACTIVE_LOW      = 1'b0,
    localparam int CODE_W         = idx_width(N_BTN)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_BTN-1:0]  BTN,
    output logic [N_BTN-1:0]  held,
    output logic [CODE_W-1:0] code,
    output logic              press_valid,
    output logic              selector
);

    logic [N_BTN-1:0]  db;
    logic [N_BTN-1:0]  db_q;
    logic [N_BTN-1:0]  rise;
    logic              any_rise;
    logic [CODE_W-1:0] rise_idx;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_db (
            .clk (CLK),
            .rst (RST),
            .raw (BTN[i]),
            .db  (db[i])
        );
    end

    // db is already a flop, so held carries no combinational path from BTN.
    assign held = db;

    always_ff @(posedge CLK) begin
        if (RST) begin
            db_q <= '0;
        end else begin
            db_q <= db;
        end
    end

    // Only press edges are events; releases are ignored.
    assign rise = db & ~db_q;

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        any_rise = 1'b0;
        rise_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (rise[i]) begin
                any_rise = 1'b1;
                rise_idx = CODE_W'(i);
            end
        end
    end

    // Button 0 always wins priority, so rise[0] alone means this cycle's
    // strobe carries code 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            code        <= '0;
            press_valid <= 1'b0;
            selector    <= 1'b0;
        end else begin
            press_valid <= any_rise;
            if (any_rise) begin
                code <= rise_idx;
            end
            if (rise[0]) begin
                selector <= ~selector;
            end
        end
    end

endmodule
